// File: rtl/pri_pkg.sv
// Shared definitions for the priority-encoder link: default code width, FSM states, one-hot helper.
package pri_pkg;

   localparam int unsigned CW_DEF = 3;
   localparam int unsigned N_DEF  = 2**CW_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   function automatic logic [N_DEF-1:0] onehot(input logic [CW_DEF-1:0] c);
      onehot = N_DEF'(1) << c;
   endfunction

endpackage

// File: rtl/pri_deco_fifo.sv
// Synchronous FIFO of encoded indices with occupancy, full and empty flags.
module pri_deco_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [CW-1:0]              din,
   input  logic                       pop,
   output logic [CW-1:0]              dout,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [CW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/pri_deco_stream.sv
// Buffered 3-to-8 decoder replaying queued indices as timed one-hot pulses.
// Optional dropped-code counter enabled by defining PRI_DECO_DROP_CNT_EN.
module pri_deco_stream
   import pri_pkg::*;
#(
   parameter int unsigned CW        = CW_DEF,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned PULSE_LEN = 1,
   parameter int unsigned GAP_LEN   = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [CW-1:0]              code,
   input  logic                       code_v,
   output logic                       in_ready,
   output logic [(2**CW)-1:0]         y,
   output logic                       y_v,
   output logic [CW-1:0]              idx,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     level
`ifdef PRI_DECO_DROP_CNT_EN
   ,
   output logic [7:0]                 drop_cnt
`endif
);

   localparam int unsigned N       = 2**CW;
   localparam int unsigned CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int unsigned CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   state_t          state_q;
   state_t          state_d;
   logic [CNTW-1:0] cnt_q;
   logic [CNTW-1:0] cnt_d;
   logic [N-1:0]    y_d;
   logic            y_v_d;
   logic [CW-1:0]   idx_d;
   logic            pop;
   logic            push;
   logic            start;
   logic            finish;
   logic [CW-1:0]   head;
   logic [N-1:0]    head_oh;
   logic            full;
   logic            empty;

   assign in_ready = en && !full;
   assign push     = code_v && in_ready;
   assign busy     = (state_q != IDLE) || !empty;

   generate
      if (CW == CW_DEF) begin : g_oh_pkg
         assign head_oh = onehot(head);
      end else begin : g_oh_shift
         assign head_oh = N'(1) << head;
      end
   endgenerate

   pri_deco_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (code),
      .pop   (pop),
      .dout  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   // Next-state and next-output logic; a finished pulse/gap either reloads or idles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      y_d     = y;
      y_v_d   = y_v;
      idx_d   = idx;
      pop     = 1'b0;
      start   = 1'b0;
      finish  = 1'b0;

      case (state_q)
         IDLE: begin
            y_d   = '0;
            y_v_d = 1'b0;
            start = en && !empty;
         end
         DRIVE: begin
            if (cnt_q == '0) begin
               if (GAP_LEN > 0) begin
                  y_d     = '0;
                  y_v_d   = 1'b0;
                  cnt_d   = CNTW'(GAP_LEN - 1);
                  state_d = GAP;
               end else begin
                  finish = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) finish = 1'b1;
            else             cnt_d  = cnt_q - CNTW'(1);
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (finish) begin
         start = en && !empty;
         if (!start) begin
            y_d     = '0;
            y_v_d   = 1'b0;
            state_d = IDLE;
         end
      end

      if (start) begin
         pop     = 1'b1;
         y_d     = head_oh;
         y_v_d   = 1'b1;
         idx_d   = head;
         cnt_d   = CNTW'(PULSE_LEN - 1);
         state_d = DRIVE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         y       <= '0;
         y_v     <= 1'b0;
         idx     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         y       <= y_d;
         y_v     <= y_v_d;
         idx     <= idx_d;
      end
   end

`ifdef PRI_DECO_DROP_CNT_EN
   // Saturating count of codes offered while the queue could not accept them.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (code_v && !in_ready && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pri_deco_stream.sv
// Bench for pri_deco_stream: two instances (pulse 1/gap 0 and pulse 3/gap 2) against a timeline model.
module tb_pri_deco_stream;

   localparam int DEPTH = 4;
   localparam int PL_A  = 1;
   localparam int GL_A  = 0;
   localparam int PL_B  = 3;
   localparam int GL_B  = 2;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       en     = 1'b0;
   logic       code_v = 1'b0;
   logic [2:0] code   = 3'd0;

   logic       in_ready [2];
   logic [7:0] y        [2];
   logic       y_v      [2];
   logic [2:0] idx      [2];
   logic       busy     [2];
   logic [2:0] level    [2];
`ifdef PRI_DECO_DROP_CNT_EN
   logic [7:0] drop     [2];
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pri_deco_stream #(.CW(3), .DEPTH(DEPTH), .PULSE_LEN(PL_A), .GAP_LEN(GL_A)) dut_a (
      .clk(clk), .rst(rst), .en(en), .code(code), .code_v(code_v),
      .in_ready(in_ready[0]), .y(y[0]), .y_v(y_v[0]), .idx(idx[0]),
      .busy(busy[0]), .level(level[0])
`ifdef PRI_DECO_DROP_CNT_EN
      , .drop_cnt(drop[0])
`endif
   );

   pri_deco_stream #(.CW(3), .DEPTH(DEPTH), .PULSE_LEN(PL_B), .GAP_LEN(GL_B)) dut_b (
      .clk(clk), .rst(rst), .en(en), .code(code), .code_v(code_v),
      .in_ready(in_ready[1]), .y(y[1]), .y_v(y_v[1]), .idx(idx[1]),
      .busy(busy[1]), .level(level[1])
`ifdef PRI_DECO_DROP_CNT_EN
      , .drop_cnt(drop[1])
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: queue of codes plus a per-cycle output timeline (code value, or -1 for a gap cycle).
   int fq    [2][$];
   int tl    [2][$];
   int m_drop[2];

   function automatic logic [31:0] m_y(input int i);
      if (tl[i].size() > 0 && tl[i][0] >= 0) return 32'(1) << tl[i][0];
      return 32'd0;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int  pl;
         int  gl;
         int  c;
         bit  ready;
         pl = (i == 0) ? PL_A : PL_B;
         gl = (i == 0) ? GL_A : GL_B;
         if (rst) begin
            fq[i].delete();
            tl[i].delete();
            m_drop[i] = 0;
         end else begin
            ready = en && (fq[i].size() < DEPTH);
            if (tl[i].size() > 0) void'(tl[i].pop_front());
            if (en && tl[i].size() == 0 && fq[i].size() > 0) begin
               c = fq[i].pop_front();
               for (int k = 0; k < pl; k++) tl[i].push_back(c);
               for (int k = 0; k < gl; k++) tl[i].push_back(-1);
            end
            if (code_v && ready) fq[i].push_back(int'(code));
            else if (code_v && m_drop[i] < 255) m_drop[i]++;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [31:0] ey;
         ey = m_y(i);
         chk($sformatf("y[%0d]", i), 32'(y[i]), ey);
         chk($sformatf("y_v[%0d]", i), 32'(y_v[i]), 32'(ey != 0));
         if (ey != 0) chk($sformatf("idx[%0d]", i), 32'(idx[i]), 32'(tl[i][0]));
         chk($sformatf("level[%0d]", i), 32'(level[i]), 32'(fq[i].size()));
         chk($sformatf("in_ready[%0d]", i), 32'(in_ready[i]), 32'(en && fq[i].size() < DEPTH));
         chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(tl[i].size() > 0 || fq[i].size() > 0));
`ifdef PRI_DECO_DROP_CNT_EN
         chk($sformatf("drop_cnt[%0d]", i), 32'(drop[i]), 32'(m_drop[i]));
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((busy[0] || busy[1]) && k < 200) begin
         cyc();
         k++;
      end
      chk("drain_timeout", 32'(busy[0] || busy[1]), 32'd0);
   endtask

   task automatic push(input int c);
      code   = 3'(c);
      code_v = 1'b1;
      cyc();
   endtask

   initial begin
      // Reset state
      cyc(); cyc();
      chk("rst_y", 32'(y[0]), 32'h0);
      chk("rst_yv", 32'(y_v[1]), 32'h0);
      chk("rst_idx", 32'(idx[1]), 32'h0);
      chk("rst_level", 32'(level[1]), 32'h0);
      chk("rst_busy", 32'(busy[0]), 32'h0);
      chk("rst_ready_en0", 32'(in_ready[0]), 32'h0);

      // Back-to-back 7 then 0, pulse 1, no gap
      rst = 1'b0;
      en  = 1'b1;
      push(7);
      push(0);
      chk("b2b_y7", 32'(y[0]), 32'h80);
      chk("b2b_idx7", 32'(idx[0]), 32'd7);
      code_v = 1'b0;
      cyc();
      chk("b2b_y0", 32'(y[0]), 32'h01);
      chk("b2b_idx0", 32'(idx[0]), 32'd0);
      cyc();
      chk("b2b_end_y", 32'(y[0]), 32'h0);
      chk("b2b_end_busy", 32'(busy[0]), 32'h0);
      drain();

      // Pulse 3 / gap 2 timing on a single code, then sweep 1..7
      push(0);
      code_v = 1'b0;
      cyc(); chk("pl3_c1", 32'(y[1]), 32'h01);
      cyc(); chk("pl3_c2", 32'(y[1]), 32'h01);
      cyc(); chk("pl3_c3", 32'(y[1]), 32'h01);
      cyc(); chk("gap_c1", 32'(y[1]), 32'h0);
      chk("gap_yv", 32'(y_v[1]), 32'h0);
      cyc(); chk("gap_c2", 32'(y[1]), 32'h0);
      cyc(); chk("gap_idle", 32'(busy[1]), 32'h0);
      for (int c = 1; c < 8; c++) begin
         int k;
         k = 0;
         while (!in_ready[1] && k < 100) begin
            cyc();
            k++;
         end
         push(c);
         code_v = 1'b0;
      end
      drain();

      // Fill the queue while the first pulse is held; sixth offer is dropped
      for (int c = 1; c <= 5; c++) push(c);
      chk("full_level", 32'(level[1]), 32'd4);
      chk("full_ready", 32'(in_ready[1]), 32'd0);
      push(6);
      chk("full_level_hold", 32'(level[1]), 32'd4);
`ifdef PRI_DECO_DROP_CNT_EN
      chk("drop_b", 32'(drop[1]), 32'd1);
      chk("drop_a", 32'(drop[0]), 32'd0);
`endif
      code_v = 1'b0;
      drain();

      // en dropped mid-pulse with two codes queued
      push(1); push(2); push(3);
      code_v = 1'b0;
      en     = 1'b0;
      cyc(); cyc(); cyc(); cyc();
      chk("en0_y", 32'(y[1]), 32'h0);
      chk("en0_level", 32'(level[1]), 32'd2);
      chk("en0_ready", 32'(in_ready[1]), 32'd0);
      cyc(); cyc(); cyc();
      chk("en0_level_hold", 32'(level[1]), 32'd2);
      en = 1'b1;
      cyc();
      chk("en1_y", 32'(y[1]), 32'h04);
      chk("en1_idx", 32'(idx[1]), 32'd2);
      drain();

      // Reset mid-pulse with three codes queued
      push(1); push(2); push(3); push(4);
      chk("pre_rst_level", 32'(level[1]), 32'd3);
      code_v = 1'b0;
      rst    = 1'b1;
      cyc();
      chk("mid_rst_y", 32'(y[1]), 32'h0);
      chk("mid_rst_yv", 32'(y_v[1]), 32'h0);
      chk("mid_rst_level", 32'(level[1]), 32'd0);
      chk("mid_rst_ready", 32'(in_ready[1]), 32'd1);
      rst = 1'b0;

      // Arbitrary code with code_v low is never queued
      for (int k = 0; k < 6; k++) begin
         code = 3'($urandom);
         cyc();
         chk("nov_y", 32'(y[0]), 32'h0);
         chk("nov_busy", 32'(busy[0]), 32'h0);
         chk("nov_level", 32'(level[1]), 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
